// File: rtl/amdc_pwm_carrier.sv
// amdc_pwm_carrier
// Triangle-carrier generator for the PWM subsystem. It produces an up/down
// count between 0 and the effective peak. It also emits one-clk event pulses
// at the peak and at the valley. Peak and prescaler are double-buffered and
// are reloaded only at start-up or at the valley, so every period is whole.
//
// Ports
//   clk               system clock
//   rst_n             asynchronous, active-low reset
//   enable            run request (level); a stop completes at the next valley
//   carrier_max       requested peak value, sampled at reload points only
//   carrier_div       requested prescaler; carrier steps every carrier_div+1 clk
//   carrier           current triangle count
//   dir               1 = counting up, 0 = counting down
//   pwm_carrier_high  one-clk pulse in the first clk where carrier == peak
//   pwm_carrier_low   one-clk pulse in the first clk where carrier returns to 0
//   load_done         one-clk pulse when the shadow peak/prescaler are reloaded
module amdc_pwm_carrier #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] carrier_max,
    input  logic [DIV_W-1:0] carrier_div,
    output logic [CNT_W-1:0] carrier,
    output logic             dir,
    output logic             pwm_carrier_high,
    output logic             pwm_carrier_low,
    output logic             load_done
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t           state;
    logic [CNT_W-1:0] shadow_max;
    logic [DIV_W-1:0] shadow_div;
    logic [DIV_W-1:0] div_cnt;

    logic [CNT_W-1:0] eff_max;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_dec;
    logic             tick;

    // A zero peak is run as 1 so the peak and valley never fall in the same clk.
    assign eff_max = (shadow_max == '0) ? CNT_W'(1) : shadow_max;
    assign tick    = (div_cnt == shadow_div);
    assign cnt_inc = carrier + CNT_W'(1);
    assign cnt_dec = carrier - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            carrier          <= '0;
            dir              <= 1'b1;
            pwm_carrier_high <= 1'b0;
            pwm_carrier_low  <= 1'b0;
            load_done        <= 1'b0;
            shadow_max       <= '0;
            shadow_div       <= '0;
            div_cnt          <= '0;
        end else begin
            // Pulses are asserted for exactly one clk.
            pwm_carrier_high <= 1'b0;
            pwm_carrier_low  <= 1'b0;
            load_done        <= 1'b0;

            case (state)
                IDLE: begin
                    carrier <= '0;
                    dir     <= 1'b1;
                    div_cnt <= '0;
                    if (enable) begin
                        shadow_max <= carrier_max;
                        shadow_div <= carrier_div;
                        load_done  <= 1'b1;
                        state      <= UP;
                    end
                end

                UP: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tick) begin
                        carrier <= cnt_inc;
                        if (cnt_inc == eff_max) begin
                            pwm_carrier_high <= 1'b1;
                            dir              <= 1'b0;
                            state            <= DOWN;
                        end
                    end
                end

                DOWN: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tick) begin
                        carrier <= cnt_dec;
                        if (cnt_dec == '0) begin
                            // Valley: the only mid-run point where new
                            // settings take effect. Carrier is 0 here, so a
                            // smaller peak cannot strand it above the peak.
                            pwm_carrier_low <= 1'b1;
                            shadow_max      <= carrier_max;
                            shadow_div      <= carrier_div;
                            load_done       <= 1'b1;
                            dir             <= 1'b1;
                            state           <= enable ? UP : IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amdc_pwm_carrier.sv
// tb_amdc_pwm_carrier
// Directed bench for amdc_pwm_carrier. The stimulus process queues the
// expected per-cycle output sample (tagged with its clk number) and drives
// inputs at fixed cycles. A separate monitor pops and compares samples on the
// falling edge of their cycle.
module tb_amdc_pwm_carrier;

    localparam int CNT_W = 16;
    localparam int DIV_W = 8;
    localparam int M     = 3;   // cycle at which reset is released and run starts

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [CNT_W-1:0] carrier_max;
    logic [DIV_W-1:0] carrier_div;
    logic [CNT_W-1:0] carrier;
    logic             dir;
    logic             pwm_carrier_high;
    logic             pwm_carrier_low;
    logic             load_done;

    amdc_pwm_carrier #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .carrier_max      (carrier_max),
        .carrier_div      (carrier_div),
        .carrier          (carrier),
        .dir              (dir),
        .pwm_carrier_high (pwm_carrier_high),
        .pwm_carrier_low  (pwm_carrier_low),
        .load_done        (load_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] carrier;
        logic             dir;
        logic             hi;
        logic             lo;
        logic             ld;
    } samp_t;

    typedef struct {
        int    cyc;
        samp_t s;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   ec    = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue n consecutive expected samples starting at cycle ec.
    task automatic ex(input int n, input int c, input bit d, input bit h,
                      input bit l, input bit ld);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc       = ec;
            e.s.carrier = CNT_W'(c);
            e.s.dir     = d;
            e.s.hi      = h;
            e.s.lo      = l;
            e.s.ld      = ld;
            q.push_back(e);
            ec++;
        end
    endtask

    // Advance to 2 time units after posedge number c.
    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: compare the DUT sample against the queued expectation.
    initial begin
        samp_t got;
        forever begin
            @(negedge clk);
            got = {carrier, dir, pwm_carrier_high, pwm_carrier_low, load_done};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL stale_expect cyc%0d: sample for cyc%0d was never checked",
                         cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                tests++;
                if (got !== q[0].s) begin
                    fails++;
                    $display("FAIL sample cyc%0d: got carrier=%0d dir=%0b hi=%0b lo=%0b ld=%0b, expected carrier=%0d dir=%0b hi=%0b lo=%0b ld=%0b",
                             cyc, got.carrier, got.dir, got.hi, got.lo, got.ld,
                             q[0].s.carrier, q[0].s.dir, q[0].s.hi, q[0].s.lo, q[0].s.ld);
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        carrier_max = 16'd4;
        carrier_div = 8'd0;

        // Expected trace, one entry per clk from cycle 1.
        ec = 1;
        ex(2, 0, 1, 0, 0, 0);                         // 1..2 in reset
        // max=4, div=0 from reset
        ex(1, 0, 1, 0, 0, 0);                         // M    idle, enable seen next edge
        ex(1, 0, 1, 0, 0, 1);                         // M+1  start load
        ex(1, 1, 1, 0, 0, 0); ex(1, 2, 1, 0, 0, 0); ex(1, 3, 1, 0, 0, 0);
        ex(1, 4, 0, 1, 0, 0);                         // M+5  peak
        ex(1, 3, 0, 0, 0, 0); ex(1, 2, 0, 0, 0, 0); ex(1, 1, 0, 0, 0, 0);
        ex(1, 0, 1, 0, 1, 1);                         // M+9  valley
        ex(1, 1, 1, 0, 0, 0); ex(1, 2, 1, 0, 0, 0); ex(1, 3, 1, 0, 0, 0);
        ex(1, 4, 0, 1, 0, 0);                         // M+13
        ex(1, 3, 0, 0, 0, 0); ex(1, 2, 0, 0, 0, 0); ex(1, 1, 0, 0, 0, 0);
        ex(1, 0, 1, 0, 1, 1);                         // M+17 loads div=2
        // div=2: each value held 3 clk, pulses 1 clk
        ex(2, 0, 1, 0, 0, 0);
        ex(3, 1, 1, 0, 0, 0); ex(3, 2, 1, 0, 0, 0); ex(3, 3, 1, 0, 0, 0);
        ex(1, 4, 0, 1, 0, 0); ex(2, 4, 0, 0, 0, 0);   // M+29 peak
        ex(3, 3, 0, 0, 0, 0); ex(3, 2, 0, 0, 0, 0); ex(3, 1, 0, 0, 0, 0);
        ex(1, 0, 1, 0, 1, 1);                         // M+41 loads max=2 div=0
        // max=2 period
        ex(1, 1, 1, 0, 0, 0);
        ex(1, 2, 0, 1, 0, 0);                         // M+43
        ex(1, 1, 0, 0, 0, 0);
        ex(1, 0, 1, 0, 1, 1);                         // M+45 loads max=0
        // max=0 treated as 1
        ex(1, 1, 0, 1, 0, 0); ex(1, 0, 1, 0, 1, 1);   // M+46, M+47
        ex(1, 1, 0, 1, 0, 0); ex(1, 0, 1, 0, 1, 1);   // M+48, M+49 loads max=4
        // enable dropped at carrier=3 ascending
        ex(1, 1, 1, 0, 0, 0); ex(1, 2, 1, 0, 0, 0); ex(1, 3, 1, 0, 0, 0);
        ex(1, 4, 0, 1, 0, 0);                         // M+53
        ex(1, 3, 0, 0, 0, 0); ex(1, 2, 0, 0, 0, 0); ex(1, 1, 0, 0, 0, 0);
        ex(1, 0, 1, 0, 1, 1);                         // M+57 valley, then idle
        ex(3, 0, 1, 0, 0, 0);                         // M+58..60 idle
        ex(1, 0, 1, 0, 0, 1);                         // M+61 restart load
        ex(1, 1, 1, 0, 0, 0); ex(1, 2, 1, 0, 0, 0); ex(1, 3, 1, 0, 0, 0);
        ex(1, 4, 0, 1, 0, 0);                         // M+65
        // reset asserted mid-clk during carrier=3 descending
        ex(2, 0, 1, 0, 0, 0);                         // M+66..67
        ex(3, 0, 1, 0, 0, 0);                         // M+68..70 idle after release
        ex(1, 0, 1, 0, 0, 1);                         // M+71
        ex(1, 1, 1, 0, 0, 0); ex(1, 2, 1, 0, 0, 0);   // M+72..73

        // Input schedule
        at_cyc(M);      rst_n = 1'b1; enable = 1'b1;
        at_cyc(M + 10); carrier_div = 8'd2;
        at_cyc(M + 27); carrier_max = 16'd2; carrier_div = 8'd0;
        at_cyc(M + 42); carrier_max = 16'd0;
        at_cyc(M + 48); carrier_max = 16'd4;
        at_cyc(M + 52); enable = 1'b0;
        at_cyc(M + 60); enable = 1'b1;
        at_cyc(M + 66); rst_n = 1'b0; enable = 1'b0;
        at_cyc(M + 68); rst_n = 1'b1;
        at_cyc(M + 70); enable = 1'b1;

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d samples left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
